// File: rtl/oam_dma_arbiter_pkg.sv
// rtl/oam_dma_arbiter_pkg.sv - addresses, sizes and state encoding for the OAM DMA bus arbiter
package oam_dma_arbiter_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN      = 256;
    localparam logic [7:0]  IDX_LAST      = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - shares the CPU bus with the sprite DMA engine, stalling the CPU during copies
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rdy,
    input  logic [7:0]  bus_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        dma_busy
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dbuf_q, dbuf_d;
    logic       parity_q, parity_d;

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            dbuf_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            dbuf_q   <= dbuf_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        dbuf_d   = dbuf_q;
        parity_d = ~parity_q;
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_we   = cpu_we;
        cpu_rdy  = 1'b0;
        dma_busy = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
                // The triggering write still reaches the bus unchanged.
                if (cpu_we && cpu_addr == DMA_REG_ADDR) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                bus_we   = 1'b0;
                bus_dout = dbuf_q;
                state_d  = parity_q ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                bus_we   = 1'b0;
                bus_dout = dbuf_q;
                state_d  = ST_READ;
            end
            ST_READ: begin
                bus_addr = {page_q, idx_q};
                bus_we   = 1'b0;
                bus_dout = dbuf_q;
                dbuf_d   = bus_din;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = dbuf_q;
                bus_we   = 1'b1;
                // idx wraps within the page; the source never crosses into the next page.
                idx_d    = idx_q + 8'd1;
                state_d  = (idx_q == IDX_LAST) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
